// File: rtl/delta_event_fifo_if.sv
// Event-FIFO bus: neuron-side spike inputs, readout handshake and status outputs.
// The master modport drives the stimulus side; the slave modport is the FIFO itself.
interface delta_event_fifo_if #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned TS_W   = 8,
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned DROP_W = 8
);
    localparam int unsigned LVL_W = $clog2(DEPTH) + 1;

    logic              spike_in;
    logic [DATA_W-1:0] diff_in;
    logic              ev_ready;
    logic              clr_ovf;
    logic              ev_valid;
    logic [TS_W-1:0]   ev_ts;
    logic [DATA_W-1:0] ev_diff;
    logic [LVL_W-1:0]  level;
    logic              ovf_flag;
    logic [DROP_W-1:0] drop_cnt;

    modport master (
        output spike_in, diff_in, ev_ready, clr_ovf,
        input  ev_valid, ev_ts, ev_diff, level, ovf_flag, drop_cnt
    );

    modport slave (
        input  spike_in, diff_in, ev_ready, clr_ovf,
        output ev_valid, ev_ts, ev_diff, level, ovf_flag, drop_cnt
    );
endinterface

// File: rtl/delta_event_fifo.sv
// Timestamps delta spikes and buffers (ts, magnitude) events in a first-word-fall-through
// FIFO with valid/ready readout, sticky overflow flag and saturating drop counter.
module delta_event_fifo #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned TS_W   = 8,
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned DROP_W = 8
) (
    input  logic                clk,
    input  logic                reset,
    delta_event_fifo_if.slave   bus
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned LVL_W = PTR_W + 1;
    localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);

    logic [TS_W-1:0]   r_ts;
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [LVL_W-1:0]  r_level;
    logic              r_ovf;
    logic [DROP_W-1:0] r_drop_cnt;
    logic [TS_W-1:0]   r_mem_ts   [DEPTH];
    logic [DATA_W-1:0] r_mem_diff [DEPTH];

    logic w_empty;
    logic w_full;
    logic w_pop;
    logic w_push;
    logic w_drop;

    // A pop frees the head slot this edge, so a full FIFO can still take a push.
    always_comb begin
        w_empty = (r_level == '0);
        w_full  = (r_level == FULL_LVL);
        w_pop   = !w_empty && bus.ev_ready;
        w_push  = bus.spike_in && (!w_full || w_pop);
        w_drop  = bus.spike_in && w_full && !w_pop;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ts       <= '0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_level    <= '0;
            r_ovf      <= 1'b0;
            r_drop_cnt <= '0;
        end else begin
            r_ts <= r_ts + TS_W'(1);
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            if (w_push && !w_pop) begin
                r_level <= r_level + LVL_W'(1);
            end else if (w_pop && !w_push) begin
                r_level <= r_level - LVL_W'(1);
            end
            // Clear wins over a coincident drop; that drop goes uncounted.
            if (bus.clr_ovf) begin
                r_ovf      <= 1'b0;
                r_drop_cnt <= '0;
            end else if (w_drop) begin
                r_ovf <= 1'b1;
                if (r_drop_cnt != '1) begin
                    r_drop_cnt <= r_drop_cnt + DROP_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && w_push) begin
            r_mem_ts[r_wr_ptr]   <= r_ts;
            r_mem_diff[r_wr_ptr] <= bus.diff_in;
        end
    end

    assign bus.ev_valid = !w_empty;
    assign bus.ev_ts    = w_empty ? '0 : r_mem_ts[r_rd_ptr];
    assign bus.ev_diff  = w_empty ? '0 : r_mem_diff[r_rd_ptr];
    assign bus.level    = r_level;
    assign bus.ovf_flag = r_ovf;
    assign bus.drop_cnt = r_drop_cnt;
endmodule
